tff_ctrl: RTL and testbench

//  Synchronous driver/reader for one time-domain storage cell (tff). Converts a digital

---
 rtl/tff_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tff_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_ctrl.sv
// tff_ctrl: write/read sequencer for one time-domain storage cell (WE pulse width in, out pulse width back).
// Optional read timeout is built when TFF_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tff_ctrl #(
  parameter int DW       = 4,
  parameter int CLR_CYC  = 2,
  parameter int SYNC_STG = 2,
  parameter int TO_CYC   = 2**DW + 8
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          wr_done,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  output logic          tff_we,
  output logic          tff_re,
  output logic          tff_rstb,
  input  logic          tff_out
);

  localparam int CLRW = $clog2(CLR_CYC + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]          state;
  logic [CLRW-1:0]     clr_cnt;
  logic [DW-1:0]       cnt;
  logic [SYNC_STG-1:0] sync;
  logic                s_out;
  logic                s_prev;
  logic                s_fall;

`ifdef TFF_CTRL_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYC + 1);
  logic [TOW-1:0] to_cnt;
`endif

  // tff_out is asynchronous to clk; only the last synchronizer stage is used.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) sync <= '0;
    else       sync <= {sync[SYNC_STG-2:0], tff_out};
  end

  assign s_out  = sync[SYNC_STG-1];
  assign s_fall = s_prev && !s_out;

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_IDLE;
      wr_ready <= 1'b0;
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      tff_we   <= 1'b0;
      tff_re   <= 1'b0;
      tff_rstb <= 1'b0;
      clr_cnt  <= '0;
      cnt      <= '0;
      s_prev   <= 1'b0;
`ifdef TFF_CTRL_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          wr_ready <= 1'b1;
          tff_rstb <= 1'b1;
          tff_we   <= 1'b0;
          tff_re   <= 1'b0;
          // Write has priority; a simultaneous read request is dropped.
          if (wr_valid && wr_ready) begin
            state    <= ST_CLEAR;
            wr_ready <= 1'b0;
            tff_rstb <= 1'b0;
            clr_cnt  <= CLRW'(CLR_CYC - 1);
            cnt      <= wr_data;
          end else if (rd_req && wr_ready) begin
            state    <= ST_READ;
            wr_ready <= 1'b0;
            tff_re   <= 1'b1;
            cnt      <= '0;
            s_prev   <= 1'b0;
`ifdef TFF_CTRL_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end

        ST_CLEAR: begin
          if (clr_cnt == '0) begin
            tff_rstb <= 1'b1;
            if (cnt == '0) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_WRITE;
              tff_we <= 1'b1;
            end
          end else begin
            clr_cnt <= clr_cnt - CLRW'(1);
          end
        end

        ST_WRITE: begin
          if (cnt == DW'(1)) begin
            tff_we <= 1'b0;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - DW'(1);
          end
        end

        ST_DONE: begin
          wr_done  <= 1'b1;
          wr_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        ST_READ: begin
          s_prev <= s_out;
          if (s_out && (cnt != '1)) cnt <= cnt + DW'(1);
`ifdef TFF_CTRL_TIMEOUT_EN
          to_cnt <= to_cnt + TOW'(1);
`endif
          if (s_fall) begin
            tff_re   <= 1'b0;
            rd_valid <= 1'b1;
            rd_data  <= cnt;
            rd_err   <= 1'b0;
            wr_ready <= 1'b1;
            state    <= ST_IDLE;
          end
`ifdef TFF_CTRL_TIMEOUT_EN
          else if (to_cnt == TOW'(TO_CYC - 1)) begin
            tff_re   <= 1'b0;
            rd_valid <= 1'b1;
            rd_data  <= cnt;
            rd_err   <= 1'b1;
            wr_ready <= 1'b1;
            state    <= ST_IDLE;
          end
`endif
        end

        default: begin
          state    <= ST_IDLE;
          tff_we   <= 1'b0;
          tff_re   <= 1'b0;
          tff_rstb <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_ctrl.sv
// tb_tff_ctrl: scoreboard bench for tff_ctrl with a behavioural storage-cell model.
// Build with or without TFF_CTRL_TIMEOUT_EN; the stuck-low read test follows the macro.
`timescale 1ns/1ps

module tb_tff_ctrl;

  localparam int DW      = 4;
  localparam int CLR_CYC = 2;
  localparam int TO_CYC  = 2**DW + 8;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic          tff_out = 1'b0;
  logic          wr_ready, wr_done, rd_valid, rd_err, tff_we, tff_re, tff_rstb;
  logic [DW-1:0] rd_data;

  tff_ctrl #(.DW(DW), .CLR_CYC(CLR_CYC), .SYNC_STG(2), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rstb(rstb),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .tff_we(tff_we), .tff_re(tff_re), .tff_rstb(tff_rstb), .tff_out(tff_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int err;
    int lat;   // -1: latency not checked
    int we;
    int acc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int we_cnt = 0, rstb_lo = 0, re_cyc = 0, overlap = 0;
  int cell_val = 0, out_left = 0;
  bit re_seen = 1'b0;
  bit force_mode = 1'b0;
  int force_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Storage cell: WE cycles accumulate, RE start emits an out pulse of that many cycles.
  initial forever begin
    @(negedge clk);
    if (!tff_rstb)   cell_val = 0;
    else if (tff_we) cell_val = cell_val + 1;
    if (!tff_re) begin
      re_seen  = 1'b0;
      out_left = 0;
      tff_out  = 1'b0;
    end else begin
      if (!re_seen) begin
        re_seen  = 1'b1;
        out_left = force_mode ? force_len : cell_val;
      end
      if (out_left > 0) begin
        tff_out  = 1'b1;
        out_left = out_left - 1;
      end else begin
        tff_out = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        wr_q.delete();
        rd_q.delete();
        we_cnt  = 0;
        rstb_lo = 0;
      end else begin
        if (tff_we)           we_cnt++;
        if (!tff_rstb)        rstb_lo++;
        if (tff_re)           re_cyc++;
        if (tff_we && tff_re) overlap++;
        if (wr_done) begin
          if (wr_q.size() == 0) begin
            check("wr_done_unexpected", 32'(wr_done), 32'd0);
          end else begin
            e = wr_q.pop_front();
            check("wr_latency", cyc - e.acc, e.lat);
            check("we_width", we_cnt, e.we);
            check("clr_width", rstb_lo, CLR_CYC);
          end
          we_cnt  = 0;
          rstb_lo = 0;
        end
        if (rd_valid) begin
          if (rd_q.size() == 0) begin
            check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
          end else begin
            e = rd_q.pop_front();
            check("rd_data", 32'(rd_data), e.data);
            check("rd_err", 32'(rd_err), e.err);
            check("re_dropped", 32'(tff_re), 32'd0);
            if (e.lat >= 0) check("rd_latency", cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check("ready_timeout", 32'(wr_ready), 32'd1);
  endtask

  task automatic push_write(input int v);
    exp_t e;
    e.data = 0; e.err = 0; e.we = v;
    e.lat  = CLR_CYC + v + 1;
    e.acc  = cyc + 1;
    wr_q.push_back(e);
  endtask

  task automatic do_write(input int v);
    wait_ready();
    wr_valid = 1'b1;
    wr_data  = DW'(v);
    push_write(v);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_ready();
  endtask

  task automatic do_read(input bit fm, input int len, input int d, input int err, input int lat);
    exp_t e;
    wait_ready();
    force_mode = fm;
    force_len  = len;
    rd_req     = 1'b1;
    e.data = d; e.err = err; e.lat = lat; e.we = 0; e.acc = cyc + 1;
    rd_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    wait_ready();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int re_before;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_tff_rstb", 32'(tff_rstb), 32'd0);
    check("rst_tff_we",   32'(tff_we),   32'd0);
    check("rst_tff_re",   32'(tff_re),   32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_wr_done",  32'(wr_done),  32'd0);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(wr_ready), 32'd1);
    check("cell_rstb_after_reset", 32'(tff_rstb), 32'd1);
    @(negedge clk);

    // Write timing, including a zero-length write
    do_write(5);
    do_write(0);

    // Read of a 7-cycle pulse, then a saturating 20-cycle pulse
    do_read(1'b1, 7, 7, 0, -1);
    do_read(1'b1, 20, 15, 0, -1);

    // Simultaneous write and read request: only the write runs
    wait_ready();
    re_before = re_cyc;
    wr_valid  = 1'b1;
    rd_req    = 1'b1;
    wr_data   = DW'(6);
    push_write(6);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    wait_ready();
    repeat (10) @(negedge clk);
    check("no_read_on_conflict", re_cyc - re_before, 0);

    // Round trip through the cell model
    for (int v = 3; v <= 12; v++) begin
      do_write(v);
      do_read(1'b0, 0, v, 0, -1);
    end

    // Reset during the third WE cycle of a write of 9
    wait_ready();
    wr_valid = 1'b1;
    wr_data  = DW'(9);
    push_write(9);
    @(negedge clk);
    wr_valid = 1'b0;
    n = 0;
    while (!tff_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("we_started", 32'(tff_we), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("abort_tff_we",   32'(tff_we),   32'd0);
    check("abort_tff_rstb", 32'(tff_rstb), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_wr_done",  32'(wr_done),  32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_abort", 32'(wr_ready), 32'd1);
    repeat (15) @(negedge clk);

    // Cell output stuck low
`ifdef TFF_CTRL_TIMEOUT_EN
    do_read(1'b1, 0, 0, 1, TO_CYC);
`else
    wait_ready();
    force_mode = 1'b1;
    force_len  = 0;
    rd_req     = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (120) @(negedge clk);
    check("re_held_stuck_low", 32'(tff_re), 32'd1);
    check("ready_low_in_read", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("abort_tff_re", 32'(tff_re), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_read_abort", 32'(wr_ready), 32'd1);
`endif

    repeat (5) @(negedge clk);
    check("we_re_overlap", overlap, 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
